axis_nibble_unpacker: RTL and testbench

//  Transmit-side counterpart of the nibble packer. Takes 16-bit stream beats with a
//  bit-count keep (0/4/8/12/16) and emits them one 4-bit nibble per beat, low nibble

---
 rtl/axis_nibble_unpacker.sv | 80 ++++++++
 tb/tb_axis_nibble_unpacker.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_nibble_unpacker.sv
// axis_nibble_unpacker: splits 16-bit keep-qualified beats into a 4-bit nibble stream with per-packet length reports
module axis_nibble_unpacker #(
    parameter int LEN_W     = 12,
    parameter bit MSN_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [15:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_last,
    input  logic [7:0]       s_keep,
    output logic [3:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [LEN_W-1:0] len_data,
    output logic             len_valid,
    output logic             err
);
    logic [15:0]      hold;
    logic [2:0]       rem;
    logic [1:0]       idx;
    logic             hold_last;
    logic [LEN_W-1:0] pkt_cnt;
    logic [LEN_W-1:0] cnt_next;
    logic [2:0]       nk;
    logic             legal;
    logic             acc;
    logic             hs;
    logic             close;

    // keep decode, handshakes and the packet-close condition
    always_comb begin
        legal    = (s_keep[1:0] == 2'b00) && (s_keep <= 8'd16);
        nk       = legal ? s_keep[4:2] : 3'd0;
        s_ready  = (rem == 3'd0) || ((rem == 3'd1) && m_ready);
        m_valid  = rem != 3'd0;
        m_data   = hold[{idx, 2'b00} +: 4];
        m_last   = hold_last && (rem == 3'd1);
        acc      = s_valid && s_ready;
        hs       = m_valid && m_ready;
        close    = (hs && m_last) || (acc && (nk == 3'd0) && s_last);
        cnt_next = (hs && !(&pkt_cnt)) ? pkt_cnt + LEN_W'(1) : pkt_cnt;
    end

    // hold word: a new beat overrides the final nibble handshake so there is no bubble
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            hold      <= '0;
            rem       <= '0;
            idx       <= '0;
            hold_last <= 1'b0;
        end else if (acc) begin
            hold      <= s_data;
            rem       <= nk;
            idx       <= MSN_FIRST ? nk[1:0] - 2'd1 : 2'd0;
            hold_last <= s_last;
        end else if (hs) begin
            rem <= rem - 3'd1;
            idx <= MSN_FIRST ? idx - 2'd1 : idx + 2'd1;
        end
    end

    // packet length accounting and error pulse
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            pkt_cnt   <= '0;
            len_data  <= '0;
            len_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err       <= acc && !legal;
            len_valid <= close;
            pkt_cnt   <= close ? '0 : cnt_next;
            if (close)
                len_data <= cnt_next;
        end
    end
endmodule

// File: tb/tb_axis_nibble_unpacker.sv
// tb_axis_nibble_unpacker: scenario tasks driving beat lists against a queue-based nibble/length model
module tb_axis_nibble_unpacker;
    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic [7:0]  s_keep = '0;
    logic        m_ready = 1'b0;
    logic        s_ready0, m_valid0, m_last0, len_valid0, err0;
    logic        s_ready1, m_valid1, m_last1, len_valid1, err1;
    logic [3:0]  m_data0, m_data1;
    logic [11:0] len_data0, len_data1;

    always #5 clk = ~clk;

    axis_nibble_unpacker #(.LEN_W(12), .MSN_FIRST(1'b0)) dut0 (
        .clk(clk), .arst(arst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready0),
        .s_last(s_last), .s_keep(s_keep), .m_data(m_data0), .m_valid(m_valid0),
        .m_ready(m_ready), .m_last(m_last0), .len_data(len_data0), .len_valid(len_valid0),
        .err(err0));

    axis_nibble_unpacker #(.LEN_W(12), .MSN_FIRST(1'b1)) dut1 (
        .clk(clk), .arst(arst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready1),
        .s_last(s_last), .s_keep(s_keep), .m_data(m_data1), .m_valid(m_valid1),
        .m_ready(m_ready), .m_last(m_last1), .len_data(len_data1), .len_valid(len_valid1),
        .err(err1));

    typedef struct {
        logic [15:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    beat_t       bq[$];
    logic [4:0]  exp_n[$], got_n[$];
    int          exp_len[$], got_len[$], nib_cyc[$], acc_cyc[$], err_cyc[$];
    int          exp_err, stall_bad, n_cmp = 0, n_bad = 0;
    bit          timeout;
    logic        o_rdy, o_mv, o_ml, o_lv, o_er;
    logic [3:0]  o_md;
    logic [11:0] o_ld;

    task automatic do_reset();
        @(negedge clk);
        arst = 1'b0;
        repeat (2) @(negedge clk);
        arst = 1'b1;
    endtask

    task automatic observe(input bit sel);
        o_rdy = sel ? s_ready1 : s_ready0;
        o_mv  = sel ? m_valid1 : m_valid0;
        o_ml  = sel ? m_last1 : m_last0;
        o_md  = sel ? m_data1 : m_data0;
        o_lv  = sel ? len_valid1 : len_valid0;
        o_ld  = sel ? len_data1 : len_data0;
        o_er  = sel ? err1 : err0;
    endtask

    task automatic push_beat(input logic [15:0] d, input logic [7:0] k, input logic l);
        beat_t b;
        b.d = d;
        b.k = k;
        b.l = l;
        bq.push_back(b);
    endtask

    // reference: every legal beat yields keep/4 nibbles, packets close on s_last
    task automatic build_model(input bit msn);
        int cnt = 0;
        exp_n.delete();
        exp_len.delete();
        exp_err = 0;
        foreach (bq[b]) begin
            int k = int'(bq[b].k);
            if (k % 4 != 0 || k > 16) begin
                exp_err++;
                k = 0;
            end
            for (int i = 0; i < k / 4; i++) begin
                int j;
                logic [15:0] w;
                j = msn ? k / 4 - 1 - i : i;
                w = bq[b].d;
                exp_n.push_back({bq[b].l && (i == k / 4 - 1), w[4*j +: 4]});
            end
            cnt += k / 4;
            if (bq[b].l) begin
                exp_len.push_back(cnt > 4095 ? 4095 : cnt);
                cnt = 0;
            end
        end
    endtask

    function automatic int nib_diff();
        if (got_n.size() != exp_n.size()) return -2;
        foreach (exp_n[i]) if (got_n[i] !== exp_n[i]) return i;
        return -1;
    endfunction

    function automatic bit len_same();
        if (got_len.size() != exp_len.size()) return 1'b0;
        foreach (exp_len[i]) if (got_len[i] != exp_len[i]) return 1'b0;
        return 1'b1;
    endfunction

    // drives bq one beat at a time and records what the selected DUT produced
    task automatic run(input bit sel, input int mode, input int budget);
        int i = 0;
        int cyc = 0;
        int idle = 0;
        bit pv = 1'b0;
        logic [4:0] pn = '0;
        got_n.delete();
        got_len.delete();
        nib_cyc.delete();
        acc_cyc.delete();
        err_cyc.delete();
        stall_bad = 0;
        while (idle < 3 && cyc < budget) begin
            s_valid = i < bq.size();
            if (s_valid) begin
                s_data = bq[i].d;
                s_keep = bq[i].k;
                s_last = bq[i].l;
            end
            m_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
            #1 observe(sel);
            if (pv && (!o_mv || {o_ml, o_md} != pn)) stall_bad++;
            if (o_mv && m_ready) begin
                got_n.push_back({o_ml, o_md});
                nib_cyc.push_back(cyc);
            end
            if (o_lv) got_len.push_back(int'(o_ld));
            if (o_er) err_cyc.push_back(cyc);
            if (s_valid && o_rdy) begin
                acc_cyc.push_back(cyc);
                i++;
            end
            pv = o_mv && !m_ready;
            pn = {o_ml, o_md};
            idle = (i >= bq.size() && !o_mv) ? idle + 1 : 0;
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        timeout = cyc >= budget;
    endtask

    task automatic test_reset();
        do_reset();
        for (int s = 0; s < 2; s++) begin
            observe(s[0]);
            n_cmp++;
            if ({o_mv, o_ml, o_md, o_lv, o_ld, o_er} !== '0 || o_rdy !== 1'b1) begin
                n_bad++;
                $display("FAIL reset dut%0d: mv=%b ml=%b md=%h lv=%b ld=%0d err=%b rdy=%b, required all zero with rdy=1",
                         s, o_mv, o_ml, o_md, o_lv, o_ld, o_er, o_rdy);
            end
        end
    endtask

    task automatic test_basic();
        int d;
        bq.delete();
        push_beat(16'hA5C3, 8'd16, 1'b1);
        build_model(1'b0);
        run(1'b0, 0, 50);
        d = nib_diff();
        n_cmp++;
        if (timeout || d != -1) begin
            n_bad++;
            $display("FAIL basic nibbles: got %0d required %0d, diff at %0d timeout=%b", got_n.size(), exp_n.size(), d, timeout);
        end
        n_cmp++;
        if (!len_same()) begin
            n_bad++;
            $display("FAIL basic len: got %0d reports first=%0d, required 1 report of 4", got_len.size(), got_len.size() > 0 ? got_len[0] : -1);
        end
        n_cmp++;
        if (nib_cyc.size() != 4 || acc_cyc.size() != 1 || nib_cyc[0] != acc_cyc[0] + 1 || nib_cyc[3] != nib_cyc[0] + 3) begin
            n_bad++;
            $display("FAIL basic timing: first nibble cycle %0d last %0d accept %0d, required accept+1 and 4 consecutive",
                     nib_cyc.size() > 0 ? nib_cyc[0] : -1, nib_cyc.size() > 3 ? nib_cyc[3] : -1, acc_cyc.size() > 0 ? acc_cyc[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        int d;
        bq.delete();
        push_beat(16'hA5C3, 8'd16, 1'b1);
        push_beat(16'h000F, 8'd4, 1'b1);
        build_model(1'b0);
        run(1'b0, 2, 100);
        d = nib_diff();
        n_cmp++;
        if (timeout || d != -1) begin
            n_bad++;
            $display("FAIL backpressure nibbles: got %0d required %0d, diff at %0d timeout=%b", got_n.size(), exp_n.size(), d, timeout);
        end
        n_cmp++;
        if (stall_bad != 0) begin
            n_bad++;
            $display("FAIL backpressure stability: %0d unstable stalled cycles, required 0", stall_bad);
        end
        n_cmp++;
        if (acc_cyc.size() != 2 || nib_cyc.size() != 5 || acc_cyc[1] != nib_cyc[3]) begin
            n_bad++;
            $display("FAIL backpressure s_ready: second beat accepted cycle %0d, required %0d",
                     acc_cyc.size() > 1 ? acc_cyc[1] : -1, nib_cyc.size() > 3 ? nib_cyc[3] : -1);
        end
        n_cmp++;
        if (!len_same()) begin
            n_bad++;
            $display("FAIL backpressure len: got %0d reports, required 2 (4,1)", got_len.size());
        end
    endtask

    task automatic test_back_to_back();
        int d;
        bq.delete();
        push_beat(16'h0021, 8'd8, 1'b0);
        push_beat(16'h0654, 8'd12, 1'b1);
        build_model(1'b0);
        run(1'b0, 0, 50);
        d = nib_diff();
        n_cmp++;
        if (timeout || d != -1) begin
            n_bad++;
            $display("FAIL back_to_back nibbles: got %0d required %0d, diff at %0d (got %h required %h)",
                     got_n.size(), exp_n.size(), d, d >= 0 ? got_n[d] : 5'h0, d >= 0 ? exp_n[d] : 5'h0);
        end
        n_cmp++;
        if (nib_cyc.size() != 5 || nib_cyc[4] != nib_cyc[0] + 4) begin
            n_bad++;
            $display("FAIL back_to_back bubbles: %0d nibbles spanning %0d cycles, required 5 over 5",
                     nib_cyc.size(), nib_cyc.size() > 0 ? nib_cyc[nib_cyc.size()-1] - nib_cyc[0] + 1 : 0);
        end
        n_cmp++;
        if (!len_same()) begin
            n_bad++;
            $display("FAIL back_to_back len: got %0d reports first=%0d, required one of 5", got_len.size(), got_len.size() > 0 ? got_len[0] : -1);
        end
    endtask

    task automatic test_keep0_err();
        int d;
        bq.delete();
        push_beat(16'h0087, 8'd8, 1'b0);
        push_beat(16'h5555, 8'd0, 1'b1);
        push_beat(16'hFFFF, 8'd7, 1'b0);
        push_beat(16'h0009, 8'd4, 1'b1);
        build_model(1'b0);
        run(1'b0, 0, 50);
        d = nib_diff();
        n_cmp++;
        if (timeout || d != -1) begin
            n_bad++;
            $display("FAIL keep0 nibbles: got %0d required %0d, diff at %0d", got_n.size(), exp_n.size(), d);
        end
        n_cmp++;
        if (!len_same()) begin
            n_bad++;
            $display("FAIL keep0 len: got %0d reports first=%0d, required 2 reports (2,1)", got_len.size(), got_len.size() > 0 ? got_len[0] : -1);
        end
        n_cmp++;
        if (err_cyc.size() != exp_err || acc_cyc.size() != 4 || err_cyc[0] != acc_cyc[2] + 1) begin
            n_bad++;
            $display("FAIL keep0 err: %0d pulses first at %0d, required %0d at %0d",
                     err_cyc.size(), err_cyc.size() > 0 ? err_cyc[0] : -1, exp_err, acc_cyc.size() > 2 ? acc_cyc[2] + 1 : -1);
        end
    endtask

    task automatic test_msn_reset();
        int d;
        do_reset();
        bq.delete();
        push_beat(16'h1234, 8'd12, 1'b1);
        build_model(1'b1);
        run(1'b1, 0, 50);
        d = nib_diff();
        n_cmp++;
        if (timeout || d != -1) begin
            n_bad++;
            $display("FAIL msn nibbles: got %0d required %0d, diff at %0d (got %h required %h)",
                     got_n.size(), exp_n.size(), d, d >= 0 ? got_n[d] : 5'h0, d >= 0 ? exp_n[d] : 5'h0);
        end
        s_valid = 1'b1;
        s_data = 16'h1234;
        s_keep = 8'd12;
        s_last = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        #1 observe(1'b1);
        n_cmp++;
        if (o_mv !== 1'b1 || o_md !== 4'h3) begin
            n_bad++;
            $display("FAIL msn pre-reset: mv=%b md=%h, required mv=1 md=3", o_mv, o_md);
        end
        #2 arst = 1'b0;
        #1 observe(1'b1);
        n_cmp++;
        if (o_mv !== 1'b0 || o_ml !== 1'b0 || o_lv !== 1'b0) begin
            n_bad++;
            $display("FAIL msn async reset: mv=%b ml=%b lv=%b, required all 0", o_mv, o_ml, o_lv);
        end
        m_ready = 1'b0;
        @(negedge clk);
        arst = 1'b1;
        bq.delete();
        push_beat(16'h00BA, 8'd8, 1'b1);
        build_model(1'b1);
        run(1'b1, 0, 50);
        d = nib_diff();
        n_cmp++;
        if (timeout || d != -1 || !len_same()) begin
            n_bad++;
            $display("FAIL msn after reset: %0d nibbles %0d reports first len=%0d, required 2 nibbles and one report of 2",
                     got_n.size(), got_len.size(), got_len.size() > 0 ? got_len[0] : -1);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 2; s++) begin
            int d;
            do_reset();
            bq.delete();
            for (int b = 0; b < 60; b++) begin
                int r = $urandom_range(0, 9);
                int k = r < 2 ? 0 : r < 9 ? 4 * $urandom_range(1, 4) : $urandom_range(0, 255);
                bit ok = (k % 4 == 0) && (k <= 16);
                if (r == 9 && ok) k = k | 1;
                ok = (k % 4 == 0) && (k <= 16);
                if (b == 59) push_beat(16'($urandom), 8'd16, 1'b1);
                else push_beat(16'($urandom), 8'(k), ok && k != 0 && $urandom_range(0, 2) == 0);
            end
            build_model(s[0]);
            run(s[0], 1, 3000);
            d = nib_diff();
            n_cmp++;
            if (timeout || d != -1) begin
                n_bad++;
                $display("FAIL random%0d nibbles: got %0d required %0d, diff at %0d (got %h required %h) timeout=%b",
                         s, got_n.size(), exp_n.size(), d, d >= 0 ? got_n[d] : 5'h0, d >= 0 ? exp_n[d] : 5'h0, timeout);
            end
            n_cmp++;
            if (!len_same()) begin
                n_bad++;
                $display("FAIL random%0d len: got %0d reports, required %0d", s, got_len.size(), exp_len.size());
            end
            n_cmp++;
            if (err_cyc.size() != exp_err || stall_bad != 0) begin
                n_bad++;
                $display("FAIL random%0d err/stall: err %0d required %0d, unstable stalls %0d required 0",
                         s, err_cyc.size(), exp_err, stall_bad);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        bq.delete();
        for (int b = 0; b < 1030; b++) push_beat(16'($urandom), 8'd16, b == 1029);
        build_model(1'b0);
        run(1'b0, 0, 6000);
        n_cmp++;
        if (timeout || nib_diff() != -1 || !len_same()) begin
            n_bad++;
            $display("FAIL saturate: %0d nibbles (required %0d), len=%0d required %0d, timeout=%b",
                     got_n.size(), exp_n.size(), got_len.size() > 0 ? got_len[0] : -1, exp_len[0], timeout);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_keep0_err();
        test_msn_reset();
        test_random();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
